// File: rtl/seq_booth_mult.sv
// Iterative radix-2 shift-add multiplier with valid/ready handshakes on both sides.
// Signed operands are multiplied as magnitudes and the sign is reapplied at completion.
module seq_booth_mult #(
    parameter int WIDTH     = 32,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   acc;
    logic [CW-1:0]      count;
    logic               res_neg;

    logic               sgn;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] acc_final;
    logic               last;

    // The magnitude of the most negative operand is still representable unsigned.
    always_comb begin
        sgn       = signed_mode & SIGNED_EN;
        mag_a     = (sgn && a[WIDTH-1]) ? -a : a;
        mag_b     = (sgn && b[WIDTH-1]) ? -b : b;
        sum       = {1'b0, acc} + {1'b0, (mplier[0] ? mcand : {WIDTH{1'b0}})};
        acc_final = {sum, mplier[WIDTH-1:1]};
        last      = (count == LAST_COUNT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = CALC;
                end
            end
            CALC: begin
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The carry out of each add is shifted into the accumulator so nothing is lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            count   <= '0;
            res_neg <= 1'b0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand   <= mag_a;
                        mplier  <= mag_b;
                        res_neg <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                        acc     <= '0;
                        count   <= '0;
                    end
                end
                CALC: begin
                    acc    <= sum[WIDTH:1];
                    mplier <= {sum[0], mplier[WIDTH-1:1]};
                    count  <= count + 1'b1;
                    if (last) begin
                        product <= res_neg ? -acc_final : acc_final;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_booth_mult.sv
// Self-checking bench: three multiplier instances (32-bit, 32-bit unsigned-only, 8-bit)
// share one stimulus stream and are compared against plain integer arithmetic.
module tb_seq_booth_mult;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        signed_mode;
    logic        out_ready;
    logic [31:0] a;
    logic [31:0] b;

    logic        rdy32, vld32;
    logic [63:0] prod32;
    logic        rdyU, vldU;
    logic [63:0] prodU;
    logic        rdy8, vld8;
    logic [15:0] prod8;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seq_booth_mult #(.WIDTH(32), .SIGNED_EN(1'b1)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy32),
        .a(a), .b(b), .signed_mode(signed_mode),
        .out_valid(vld32), .out_ready(out_ready), .product(prod32)
    );

    seq_booth_mult #(.WIDTH(32), .SIGNED_EN(1'b0)) dutU (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdyU),
        .a(a), .b(b), .signed_mode(signed_mode),
        .out_valid(vldU), .out_ready(out_ready), .product(prodU)
    );

    seq_booth_mult #(.WIDTH(8), .SIGNED_EN(1'b1)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy8),
        .a(a[7:0]), .b(b[7:0]), .signed_mode(signed_mode),
        .out_valid(vld8), .out_ready(out_ready), .product(prod8)
    );

    function automatic logic [63:0] model64(input logic [31:0] x, input logic [31:0] y,
                                            input logic sm);
        longint p;
        if (sm) begin
            p = longint'($signed(x)) * longint'($signed(y));
            return 64'(p);
        end
        return {32'b0, x} * {32'b0, y};
    endfunction

    function automatic logic [15:0] model16(input logic [7:0] x, input logic [7:0] y,
                                            input logic sm);
        int p;
        if (sm) begin
            p = int'($signed(x)) * int'($signed(y));
        end else begin
            p = int'(x) * int'(y);
        end
        return p[15:0];
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issues one operation, floods the input with garbage while busy, holds off the
    // consumer for 'hold' extra cycles, then completes the handshake.
    task automatic applyStimulus(input logic [31:0] x, input logic [31:0] y,
                                 input logic sm, input int hold);
        logic [63:0] e32, eU;
        logic [15:0] e8;
        int lat32, latU, lat8;
        logic busyReady;
        e32 = model64(x, y, sm);
        eU  = model64(x, y, 1'b0);
        e8  = model16(x[7:0], y[7:0], sm);
        lat32 = -1; latU = -1; lat8 = -1;
        busyReady = 1'b0;

        @(negedge clk);
        checkOutput("idle_ready", {61'b0, rdy32, rdyU, rdy8}, 64'd7);
        a = x; b = y; signed_mode = sm; in_valid = 1'b1;
        @(negedge clk);
        for (int n = 1; n <= 40; n++) begin
            a = $urandom; b = $urandom; signed_mode = 1'($urandom); in_valid = 1'b1;
            @(negedge clk);
            if (vld32 && lat32 < 0) lat32 = n;
            if (vldU && latU < 0) latU = n;
            if (vld8 && lat8 < 0) lat8 = n;
            if ((!vld32 && rdy32) || (!vldU && rdyU) || (!vld8 && rdy8)) busyReady = 1'b1;
            if (vld32 && vldU && vld8) break;
        end
        checkOutput("latency32", 64'(lat32), 64'd32);
        checkOutput("latencyU", 64'(latU), 64'd32);
        checkOutput("latency8", 64'(lat8), 64'd8);
        checkOutput("ready_busy", {63'b0, busyReady}, 64'd0);

        repeat (hold) @(negedge clk);
        in_valid = 1'b0;
        checkOutput("valid_held", {61'b0, vld32, vldU, vld8}, 64'd7);
        checkOutput("ready_done", {61'b0, rdy32, rdyU, rdy8}, 64'd0);
        checkOutput("product32", prod32, e32);
        checkOutput("productU", prodU, eU);
        checkOutput("product8", {48'b0, prod8}, {48'b0, e8});

        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("valid_cleared", {61'b0, vld32, vldU, vld8}, 64'd0);
        checkOutput("ready_again", {61'b0, rdy32, rdyU, rdy8}, 64'd7);
        checkOutput("product32_kept", prod32, e32);
        checkOutput("product8_kept", {48'b0, prod8}, {48'b0, e8});
    endtask

    initial begin
        logic spurious;
        rst = 1'b1; in_valid = 1'b1; signed_mode = 1'b0; out_ready = 1'b0;
        a = 32'd3; b = 32'd4;
        repeat (2) @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        checkOutput("reset_valid", {61'b0, vld32, vldU, vld8}, 64'd0);
        checkOutput("reset_ready", {61'b0, rdy32, rdyU, rdy8}, 64'd7);
        checkOutput("reset_product32", prod32, 64'd0);
        checkOutput("reset_product8", {48'b0, prod8}, 64'd0);

        applyStimulus(32'd10, 32'd15, 1'b0, 0);
        applyStimulus(32'd25, 32'd25, 1'b0, 0);
        applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1);
        applyStimulus(32'hFFFF_FFFF, 32'd5, 1'b1, 0);
        applyStimulus(32'h8000_0000, 32'h8000_0000, 1'b1, 2);
        applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
        applyStimulus(32'd31, 32'd15, 1'b0, 10);
        applyStimulus(32'h0000_0080, 32'h0000_007F, 1'b1, 0);
        applyStimulus(32'd0, 32'h8000_0000, 1'b1, 0);
        applyStimulus(32'h8765_4321, 32'd0, 1'b1, 3);

        // Reset lands on the sixteenth iteration edge of 31*15.
        @(negedge clk);
        a = 32'd31; b = 32'd15; signed_mode = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (15) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midreset_valid", {61'b0, vld32, vldU, vld8}, 64'd0);
        checkOutput("midreset_ready", {61'b0, rdy32, rdyU, rdy8}, 64'd7);
        checkOutput("midreset_product32", prod32, 64'd0);
        checkOutput("midreset_product8", {48'b0, prod8}, 64'd0);
        spurious = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (vld32 || vldU || vld8) spurious = 1'b1;
        end
        checkOutput("no_valid_after_reset", {63'b0, spurious}, 64'd0);
        applyStimulus(32'd7, 32'd9, 1'b0, 0);

        for (int i = 0; i < 12; i++) begin
            logic [31:0] rx, ry;
            rx = $urandom;
            ry = $urandom;
            case ($urandom_range(0, 5))
                0: rx = 32'h8000_0000;
                1: ry = 32'hFFFF_FFFF;
                2: rx = 32'd0;
                default: ;
            endcase
            applyStimulus(rx, ry, 1'($urandom), int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
